// File: rtl/sprite_layer_engine.sv
// Multi-sprite position registers with per-frame button movement and a
// 2-stage pixel hit-test pipeline (lowest sprite index wins on overlap).
module sprite_layer_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int SPRITE_W    = 50,
  parameter int SPRITE_H    = 50,
  parameter int STEP        = 1,
  parameter int IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   screen_end,
  input  logic [9:0]             x,
  input  logic [8:0]             y,
  input  logic [NUM_SPRITES-1:0] up,
  input  logic [NUM_SPRITES-1:0] down,
  input  logic [NUM_SPRITES-1:0] left,
  input  logic [NUM_SPRITES-1:0] right,
  input  logic                   load_en,
  input  logic [IDX_W-1:0]       load_idx,
  input  logic [9:0]             load_x,
  input  logic [8:0]             load_y,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx,
  output logic [9:0]             rel_x,
  output logic [8:0]             rel_y,
  output logic                   frame_tick
);

  localparam logic [10:0] X_MAX  = 11'(WIDTH - SPRITE_W);
  localparam logic [10:0] Y_MAX  = 11'(HEIGHT - SPRITE_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] SW11   = 11'(SPRITE_W);
  localparam logic [10:0] SH11   = 11'(SPRITE_H);

  logic r_screen_end_q;
  logic w_frame_tick;

  assign w_frame_tick = screen_end & ~r_screen_end_q;
  // The raw edge detect would fire while reset holds r_screen_end_q low.
  assign frame_tick   = w_frame_tick & ~reset;

  always_ff @(posedge clk) begin
    if (reset) r_screen_end_q <= 1'b0;
    else       r_screen_end_q <= screen_end;
  end

  logic [9:0] w_load_x_cl;
  logic [8:0] w_load_y_cl;

  assign w_load_x_cl = ({1'b0, load_x} > X_MAX) ? X_MAX[9:0] : load_x;
  assign w_load_y_cl = ({2'b0, load_y} > Y_MAX) ? Y_MAX[8:0] : load_y;

  logic [NUM_SPRITES-1:0] w_hit_vec;
  logic [9:0]             w_off_x [NUM_SPRITES];
  logic [8:0]             w_off_y [NUM_SPRITES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      logic [9:0]  r_pos_x;
      logic [8:0]  r_pos_y;
      logic        r_cover;
      logic [9:0]  r_off_x;
      logic [8:0]  r_off_y;
      logic [10:0] w_x_ext, w_y_ext;
      logic [10:0] w_x_dec, w_x_inc, w_y_dec, w_y_inc;
      logic [9:0]  w_x_next;
      logic [8:0]  w_y_next;
      logic        w_cover;

      assign w_x_ext = {1'b0, r_pos_x};
      assign w_y_ext = {2'b0, r_pos_y};
      assign w_x_dec = w_x_ext - STEP11;
      assign w_x_inc = w_x_ext + STEP11;
      assign w_y_dec = w_y_ext - STEP11;
      assign w_y_inc = w_y_ext + STEP11;

      // Bit 10 of the decrement acts as the borrow, i.e. the result went negative.
      always_comb begin
        w_x_next = r_pos_x;
        w_y_next = r_pos_y;
        if (w_frame_tick) begin
          if (left[gi] && !right[gi])
            w_x_next = w_x_dec[10] ? 10'd0 : w_x_dec[9:0];
          else if (right[gi] && !left[gi])
            w_x_next = (w_x_inc > X_MAX) ? X_MAX[9:0] : w_x_inc[9:0];
          if (up[gi] && !down[gi])
            w_y_next = w_y_dec[10] ? 9'd0 : w_y_dec[8:0];
          else if (down[gi] && !up[gi])
            w_y_next = (w_y_inc > Y_MAX) ? Y_MAX[8:0] : w_y_inc[8:0];
        end
        if (load_en && (load_idx == IDX_W'(gi))) begin
          w_x_next = w_load_x_cl;
          w_y_next = w_load_y_cl;
        end
      end

      assign w_cover = ({1'b0, x} >= w_x_ext) && ({1'b0, x} < (w_x_ext + SW11)) &&
                       ({2'b0, y} >= w_y_ext) && ({2'b0, y} < (w_y_ext + SH11));

      // Offsets are captured alongside the compare so a later move cannot skew rel_x/rel_y.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pos_x <= 10'(gi * SPRITE_W);
          r_pos_y <= 9'd0;
          r_cover <= 1'b0;
          r_off_x <= 10'd0;
          r_off_y <= 9'd0;
        end else begin
          r_pos_x <= w_x_next;
          r_pos_y <= w_y_next;
          r_cover <= w_cover;
          r_off_x <= x - r_pos_x;
          r_off_y <= y - r_pos_y;
        end
      end

      assign w_hit_vec[gi] = r_cover;
      assign w_off_x[gi]   = r_off_x;
      assign w_off_y[gi]   = r_off_y;
    end
  endgenerate

  logic             w_win_hit;
  logic [IDX_W-1:0] w_win_idx;
  logic [9:0]       w_win_rx;
  logic [8:0]       w_win_ry;

  // Scan from the top down so the lowest covering index is the last one written.
  always_comb begin
    w_win_hit = 1'b0;
    w_win_idx = '0;
    w_win_rx  = 10'd0;
    w_win_ry  = 9'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_win_hit = 1'b1;
        w_win_idx = IDX_W'(i);
        w_win_rx  = w_off_x[i];
        w_win_ry  = w_off_y[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit     <= 1'b0;
      hit_idx <= '0;
      rel_x   <= 10'd0;
      rel_y   <= 9'd0;
    end else begin
      hit     <= w_win_hit;
      hit_idx <= w_win_idx;
      rel_x   <= w_win_rx;
      rel_y   <= w_win_ry;
    end
  end

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Directed bench for sprite_layer_engine: hit-test latency, movement,
// clamping, load priority, overlap priority and mid-stream reset.
module tb_sprite_layer_engine;

  logic       clk;
  logic       reset;
  logic       screen_end;
  logic [9:0] x;
  logic [8:0] y;
  logic [3:0] up, down, left, right;
  logic       load_en;
  logic [1:0] load_idx;
  logic [9:0] load_x;
  logic [8:0] load_y;
  logic       hit;
  logic [1:0] hit_idx;
  logic [9:0] rel_x;
  logic [8:0] rel_y;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int ticks  = 0;

  sprite_layer_engine dut (
    .clk        (clk),
    .reset      (reset),
    .screen_end (screen_end),
    .x          (x),
    .y          (y),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .load_x     (load_x),
    .load_y     (load_y),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .rel_x      (rel_x),
    .rel_y      (rel_y),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a pixel on a falling edge; the result is visible after two rising edges.
  task automatic probe(input string tag, input int px, input int py,
                       input int e_hit, input int e_idx, input int e_rx, input int e_ry);
    x = 10'(px);
    y = 9'(py);
    @(negedge clk);
    @(negedge clk);
    $display("probe %s (%0d,%0d): hit=%0d idx=%0d rel=(%0d,%0d)",
             tag, px, py, hit, hit_idx, rel_x, rel_y);
    check({tag, "_hit"}, int'(hit), e_hit);
    check({tag, "_idx"}, int'(hit_idx), e_idx);
    check({tag, "_rx"}, int'(rel_x), e_rx);
    check({tag, "_ry"}, int'(rel_y), e_ry);
  endtask

  task automatic do_frame(input int hold);
    screen_end = 1'b1;
    for (int k = 0; k < hold; k++) begin
      #1;
      if (frame_tick === 1'b1) ticks++;
      @(negedge clk);
    end
    screen_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input int idx, input int lx, input int ly);
    load_en  = 1'b1;
    load_idx = 2'(idx);
    load_x   = 10'(lx);
    load_y   = 9'(ly);
    @(negedge clk);
    load_en  = 1'b0;
    $display("load sprite %0d <- (%0d,%0d)", idx, lx, ly);
  endtask

  initial begin
    reset = 1'b1; screen_end = 1'b0; x = '0; y = '0;
    up = '0; down = '0; left = '0; right = '0;
    load_en = 1'b0; load_idx = '0; load_x = '0; load_y = '0;

    // Reset state: pixel (0,0) would hit, but reset holds outputs low.
    repeat (2) @(negedge clk);
    check("rst_hit", int'(hit), 0);
    check("rst_idx", int'(hit_idx), 0);
    check("rst_rx", int'(rel_x), 0);
    check("rst_ry", int'(rel_y), 0);
    check("rst_tick", int'(frame_tick), 0);
    reset = 1'b0;

    // 1: hit test at reset positions (0,0),(50,0),(100,0),(150,0)
    probe("t1_a", 0, 0, 1, 0, 0, 0);
    probe("t1_b", 50, 0, 1, 1, 0, 0);
    probe("t1_c", 49, 49, 1, 0, 49, 49);
    probe("t1_d", 49, 50, 0, 0, 0, 0);
    probe("t1_e", 199, 10, 1, 3, 49, 10);
    probe("t1_f", 200, 0, 0, 0, 0, 0);

    // 2: three frames with screen_end held 4 cycles each
    right[0] = 1'b1;
    ticks = 0;
    repeat (3) do_frame(4);
    right[0] = 1'b0;
    check("t2_ticks", ticks, 3);
    probe("t2_a", 2, 0, 0, 0, 0, 0);
    probe("t2_b", 3, 0, 1, 0, 0, 0);
    probe("t2_c", 52, 0, 1, 0, 49, 0);

    // 3: overlap priority
    do_load(2, 0, 0);
    probe("t3_a", 10, 10, 1, 0, 7, 10);
    do_load(0, 300, 300);
    probe("t3_b", 10, 10, 1, 2, 10, 10);

    // 4: clamping
    up[1] = 1'b1;
    ticks = 0;
    repeat (5) do_frame(2);
    up[1] = 1'b0;
    check("t4_ticks", ticks, 5);
    probe("t4_a", 60, 0, 1, 1, 10, 0);
    do_load(1, 700, 0);
    right[1] = 1'b1;
    repeat (3) do_frame(2);
    right[1] = 1'b0;
    probe("t4_b", 639, 10, 1, 1, 49, 10);
    probe("t4_c", 589, 10, 0, 0, 0, 0);
    do_load(0, 300, 500);
    probe("t4_d", 300, 479, 1, 0, 0, 49);
    probe("t4_e", 300, 480, 0, 0, 0, 0);

    // 5: opposing directions cancel, diagonal axis still moves
    up[3] = 1'b1; down[3] = 1'b1; right[3] = 1'b1;
    do_frame(1);
    up[3] = 1'b0; down[3] = 1'b0; right[3] = 1'b0;
    probe("t5_a", 151, 0, 1, 3, 0, 0);
    probe("t5_b", 150, 0, 0, 0, 0, 0);
    probe("t5_c", 151, 49, 1, 3, 0, 49);
    // load on the frame_tick cycle beats movement; sprite 2 still moves
    screen_end = 1'b1; right[3] = 1'b1; right[2] = 1'b1;
    load_en = 1'b1; load_idx = 2'd3; load_x = 10'd400; load_y = 9'd200;
    #1;
    check("t5_tick", int'(frame_tick), 1);
    @(negedge clk);
    load_en = 1'b0; screen_end = 1'b0; right = '0;
    @(negedge clk);
    probe("t5_d", 400, 200, 1, 3, 0, 0);
    probe("t5_e", 0, 0, 0, 0, 0, 0);
    probe("t5_f", 1, 0, 1, 2, 0, 0);

    // 6: reset mid-stream
    x = 10'd400; y = 9'd200;
    repeat (2) @(negedge clk);
    check("t6_pre_hit", int'(hit), 1);
    reset = 1'b1; screen_end = 1'b1;
    @(negedge clk);
    check("t6_rst_hit", int'(hit), 0);
    check("t6_rst_tick", int'(frame_tick), 0);
    @(negedge clk);
    reset = 1'b0; screen_end = 1'b0;
    x = 10'd0; y = 9'd0;
    @(negedge clk);
    check("t6_lat1_hit", int'(hit), 0);
    @(negedge clk);
    check("t6_lat2_hit", int'(hit), 1);
    check("t6_lat2_idx", int'(hit_idx), 0);
    probe("t6_a", 150, 0, 1, 3, 0, 0);
    probe("t6_b", 400, 200, 0, 0, 0, 0);
    probe("t6_c", 60, 5, 1, 1, 10, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_layer_engine.md
Name: sprite_layer_engine

Overview:
Multi-sprite position and hit-test engine for the VGA output path, generalising the single movable square to NUM_SPRITES independently positioned rectangles. Positions move by button inputs once per frame and clamp to the visible area, with no wrap-around. Each pixel's x/y is hit-tested against all sprites. The winning sprite index and the sprite-relative offset are delivered with a fixed 2-cycle latency, aligned to the two-stage image/palette RAM read, for muxing against the background colour.

Parameters:
NUM_SPRITES, 4, number of sprites (1..8)
WIDTH, 640, visible width in pixels
HEIGHT, 480, visible height in pixels
SPRITE_W, 50, sprite width in pixels
SPRITE_H, 50, sprite height in pixels
STEP, 1, pixels moved per frame per pressed direction
IDX_W, 2, width of sprite index, equal to max(1, clog2(NUM_SPRITES))

Ports:
clk  in  1  100 MHz system clock; all logic on rising edge
reset  in  1  synchronous, active-high
screen_end  in  1  high while the timing generator is between frames; may stay high for several clk cycles
x  in  10  current pixel column
y  in  9  current pixel row
up  in  NUM_SPRITES  per-sprite move-up request
down  in  NUM_SPRITES  per-sprite move-down request
left  in  NUM_SPRITES  per-sprite move-left request
right  in  NUM_SPRITES  per-sprite move-right request
load_en  in  1  direct position write
load_idx  in  IDX_W  sprite to write
load_x  in  10  new x
load_y  in  9  new y
hit  out  1  pixel (x,y) from 2 cycles earlier lies inside some sprite
hit_idx  out  IDX_W  lowest-index sprite covering that pixel; 0 when hit=0
rel_x  out  10  x minus winning sprite x; 0 when hit=0
rel_y  out  9  y minus winning sprite y; 0 when hit=0
frame_tick  out  1  one-cycle pulse on the cycle positions update

Behaviour:
- Reset: sprite i position is (i*SPRITE_W, 0). hit, hit_idx, rel_x, rel_y and frame_tick are all 0. Pipeline registers are cleared.
- Reset mid-frame: the reset state is restored on the next clock edge. Outputs are 0 for the following 2 cycles, and the first valid result is for the pixel sampled after reset is deasserted.
- Frame update:
  - Register screen_end; frame_tick = screen_end & ~screen_end_q.
  - Movement is applied only on frame_tick, so exactly one step per frame regardless of how long screen_end is held.
- Per sprite, on frame_tick:
  - up&~down: y = max(y-STEP, 0).
  - down&~up: y = min(y+STEP, HEIGHT-SPRITE_H).
  - Apply the same rule independently to left/right on x, with bounds 0 and WIDTH-SPRITE_W.
  - Both directions of an axis pressed: no motion on that axis. Diagonal motion is allowed.
  - Arithmetic is 11-bit so subtract and add cannot wrap before clamping.
- load_en: on the clock edge, write sprite load_idx with load_x clamped to WIDTH-SPRITE_W and load_y clamped to HEIGHT-SPRITE_H.
  - Takes priority over movement for that sprite in the same cycle.
  - Other sprites still move.
  - load_idx >= NUM_SPRITES is ignored.
- Hit test (half-open): sprite i covers (x,y) iff xi <= x < xi+SPRITE_W and yi <= y < yi+SPRITE_H.
  - Stage 1 (cycle N+1): register the per-sprite compare vector and x, y.
  - Stage 2 (cycle N+2): priority-encode (lowest index wins), compute rel_x/rel_y, register outputs.
  - Latency is exactly 2 clk cycles, with throughput of one pixel per clk.
- Stage 1 uses positions as of cycle N. A position change in cycle N affects pixels sampled from N+1 onward.
- No internal gating on the active region. x/y outside the visible area simply produce hit=0 unless they fall inside a sprite's range.

Test Plan:
1. Reset, then x=0,y=0 → 2 cycles later hit=1, hit_idx=0, rel=(0,0). x=50,y=0 → hit_idx=1, rel_x=0. x=49,y=49 → idx 0, rel (49,49). x=49,y=50 → hit=0.
2. Hold right[0]=1 with screen_end high for 4 cycles, 3 frames → sprite0 x=3 and frame_tick pulses 3 times. Pixel (2,0) then gives hit=0; pixel (3,0) gives hit=1, idx 0.
3. Overlap: load sprite2 to (0,0) → pixel (10,10) gives hit_idx=0. Load sprite0 to (300,300) → pixel (10,10) gives hit_idx=2, rel (10,10).
4. Clamp: sprite1 at y=0, up[1] held 5 frames → y stays 0. Load x=700 → x=590; right held → x stays 590, pixel (639,10) hits with rel_x=49.
5. Simultaneous: up[3]&down[3]&right[3] for 1 frame → y unchanged, x+1. load_en to sprite 3 on the frame_tick cycle → loaded value wins.
6. Reset asserted mid-stream while hit=1 → hit=0 next cycle. Positions return to (i*50,0), and the first valid output appears 2 cycles after reset is released.
